// File: rtl/alu_muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package alu_muldiv_pkg;

  localparam int WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEG_A,
    S_NEG_B,
    S_ITER,
    S_FIX_LO,
    S_FIX_HI,
    S_DONE
  } state_e;

endpackage

// File: rtl/alu_muldiv_sequencer_msb_carry_calc.sv
// Recovers the ALU carry-out (or no-borrow when sub=1) from the operand and result MSBs.
module msb_carry_calc (
  input  logic a31,
  input  logic b31,
  input  logic r31,
  input  logic sub,
  output logic carry
);

  logic bb;

  // A subtract feeds ~b into the adder, so the effective MSB is inverted.
  assign bb    = sub ? ~b31 : b31;
  assign carry = (a31 & bb) | ((a31 | bb) & ~r31);

endmodule

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that borrows the EX-stage ALU; busy stalls the pipe.
// Optional macro MULDIV_DIV0_FLAG_EN adds a sticky div_by_zero output.
module alu_muldiv_sequencer
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH     = alu_muldiv_pkg::WIDTH,
  parameter int ITER_BITS = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_operation,
  output logic             alu_anegate,
  output logic             alu_bnegate,
  output logic             alu_signed,
  output logic             alu_carry,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
`ifdef MULDIV_DIV0_FLAG_EN
  , output logic           div_by_zero
`endif
);

  localparam logic [ITER_BITS-1:0] LAST_ITER = ITER_BITS'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [ITER_BITS-1:0] cnt_q, cnt_d;
  logic                 sa_q, sa_d, sb_q, sb_d, mul_q, mul_d, lz_q, lz_d;
  logic [WIDTH-1:0]     sh;
  logic                 cy;
  logic                 nb;

  assign sh = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign nb = hi_q[WIDTH-1] | cy;

  msb_carry_calc u_carry (
    .a31   (alu_a[WIDTH-1]),
    .b31   (alu_b[WIDTH-1]),
    .r31   (alu_result[WIDTH-1]),
    .sub   (alu_bnegate),
    .carry (cy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      mul_q   <= 1'b0;
      lz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      mul_q   <= mul_d;
      lz_q    <= lz_d;
    end
  end

  // ALU controls depend only on registered state so the external ALU path stays loop-free.
  always_comb begin
    alu_a         = '0;
    alu_b         = '0;
    alu_operation = ALU_AND;
    alu_anegate   = 1'b0;
    alu_bnegate   = 1'b0;
    alu_signed    = 1'b0;
    alu_carry     = (state_q != S_IDLE) && (state_q != S_DONE);
    case (state_q)
      S_NEG_A: begin
        alu_a         = mul_q ? m_q : lo_q;
        alu_operation = ALU_ADD;
        alu_anegate   = 1'b1;
      end
      S_NEG_B: begin
        alu_a         = mul_q ? lo_q : m_q;
        alu_operation = ALU_ADD;
        alu_anegate   = 1'b1;
      end
      S_ITER: begin
        alu_a         = mul_q ? hi_q : sh;
        alu_b         = m_q;
        alu_operation = ALU_ADD;
        alu_bnegate   = ~mul_q;
      end
      S_FIX_LO: begin
        alu_a         = lo_q;
        alu_operation = ALU_ADD;
        alu_anegate   = 1'b1;
      end
      S_FIX_HI: begin
        alu_a       = hi_q;
        alu_anegate = 1'b1;
        // A non-zero low word absorbs the +1, so the high word only needs inverting.
        if (mul_q && !lz_q) begin
          alu_b         = '1;
          alu_operation = ALU_AND;
        end else begin
          alu_operation = ALU_ADD;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    mul_d   = mul_q;
    lz_d    = lz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mul_d = ~op[1];
          sa_d  = ~op[0] & rs[WIDTH-1];
          sb_d  = ~op[0] & rt[WIDTH-1];
          cnt_d = '0;
          hi_d  = '0;
          lo_d  = op[1] ? rs : rt;
          m_d   = op[1] ? rt : rs;
          if (op[1] && (rt == '0)) begin
            hi_d    = rs;
            lo_d    = '1;
            state_d = S_DONE;
          end else if (sa_d) begin
            state_d = S_NEG_A;
          end else if (sb_d) begin
            state_d = S_NEG_B;
          end else begin
            state_d = S_ITER;
          end
        end
      end
      S_NEG_A: begin
        if (mul_q) m_d = alu_result;
        else       lo_d = alu_result;
        state_d = sb_q ? S_NEG_B : S_ITER;
      end
      S_NEG_B: begin
        if (mul_q) lo_d = alu_result;
        else       m_d = alu_result;
        state_d = S_ITER;
      end
      S_ITER: begin
        cnt_d = cnt_q + ITER_BITS'(1);
        if (mul_q) begin
          if (lo_q[0]) {hi_d, lo_d} = {cy, alu_result, lo_q[WIDTH-1:1]};
          else         {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
        end else begin
          hi_d = nb ? alu_result : sh;
          lo_d = {lo_q[WIDTH-2:0], nb};
        end
        if (cnt_q == LAST_ITER) begin
          if (sa_q ^ sb_q)       state_d = S_FIX_LO;
          else if (!mul_q && sa_q) state_d = S_FIX_HI;
          else                   state_d = S_DONE;
        end
      end
      S_FIX_LO: begin
        lo_d    = alu_result;
        lz_d    = alu_zero;
        state_d = (mul_q || sa_q) ? S_FIX_HI : S_DONE;
      end
      S_FIX_HI: begin
        hi_d    = alu_result;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

`ifdef MULDIV_DIV0_FLAG_EN
  logic dz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dz_q <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      dz_q <= op[1] && (rt == '0);
    end
  end

  assign div_by_zero = dz_q;
`endif

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Directed bench for alu_muldiv_sequencer with a behavioural ALU closing the loop.
module tb_alu_muldiv_sequencer;
  import alu_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs = '0, rt = '0;
  logic        busy, done;
  logic [31:0] hi, lo, alu_a, alu_b, alu_result;
  logic [1:0]  alu_operation;
  logic        alu_anegate, alu_bnegate, alu_signed, alu_carry, alu_zero;
`ifdef MULDIV_DIV0_FLAG_EN
  logic        div_by_zero;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_muldiv_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs(rs), .rt(rt),
    .busy(busy), .done(done), .hi(hi), .lo(lo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation),
    .alu_anegate(alu_anegate), .alu_bnegate(alu_bnegate),
    .alu_signed(alu_signed), .alu_carry(alu_carry),
    .alu_result(alu_result), .alu_zero(alu_zero)
`ifdef MULDIV_DIV0_FLAG_EN
    , .div_by_zero(div_by_zero)
`endif
  );

  // Carry-in is applied only when an operand is being inverted (two's complement negate/subtract).
  logic [31:0] ea, eb, esum;
  always_comb begin
    ea   = alu_anegate ? ~alu_a : alu_a;
    eb   = alu_bnegate ? ~alu_b : alu_b;
    esum = ea + eb + {31'd0, alu_carry & (alu_anegate | alu_bnegate)};
    case (alu_operation)
      ALU_AND: alu_result = ea & eb;
      ALU_OR:  alu_result = ea | eb;
      ALU_ADD: alu_result = esum;
      default: alu_result = {31'd0, esum[31]};
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic check_alu_idle(input string name);
    vectors++;
    if ({alu_a, alu_b, alu_operation, alu_anegate, alu_bnegate, alu_signed, alu_carry} !== '0) begin
      miscompares++;
      $display("FAIL %s: alu a=%h b=%h op=%b an=%b bn=%b s=%b c=%b, required all zero",
               name, alu_a, alu_b, alu_operation, alu_anegate, alu_bnegate, alu_signed, alu_carry);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vectors++;
    if ({busy, done} !== 2'b00 || hi !== 32'd0 || lo !== 32'd0) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, required 0/0/0/0", busy, done, hi, lo);
    end
    check_alu_idle("reset_alu");
`ifdef MULDIV_DIV0_FLAG_EN
    vectors++;
    if (div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_dz: div_by_zero=%b, required 0", div_by_zero);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Accept happens on the first posedge after the drive; cycle k is observed at the k-th negedge after it.
  task automatic test_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int ecyc, input bit hold);
    int got;
    got = -1;
    start = 1'b1; op = o; rs = a; rt = b;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (k == 1 && ecyc > 1) begin
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          miscompares++;
          $display("FAIL %s_busy: busy=%b done=%b at cycle 1, required 1/0", name, busy, done);
        end
      end
      if (done === 1'b1) begin
        got = k;
        break;
      end
    end
    start = 1'b0;
    vectors++;
    if (got != ecyc) begin
      miscompares++;
      $display("FAIL %s_latency: done at cycle %0d, required %0d", name, got, ecyc);
    end
    vectors++;
    if (hi !== ehi || lo !== elo) begin
      miscompares++;
      $display("FAIL %s_result: hi=%h lo=%h, required hi=%h lo=%h", name, hi, lo, ehi, elo);
    end
    for (int k = 0; k < (hold ? 4 : 1); k++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_after: busy=%b done=%b %0d cycles after done, required 0/0", name, busy, done, k + 1);
      end
    end
  endtask

  task automatic test_div0();
    test_op("divu_zero", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1, 1'b0);
    check_alu_idle("idle_after_div0");
`ifdef MULDIV_DIV0_FLAG_EN
    repeat (3) @(negedge clk);
    vectors++;
    if (div_by_zero !== 1'b1) begin
      miscompares++;
      $display("FAIL dz_sticky: div_by_zero=%b, required 1", div_by_zero);
    end
    test_op("divu_after_dz", OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 33, 1'b0);
    vectors++;
    if (div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL dz_clear: div_by_zero=%b, required 0", div_by_zero);
    end
`endif
  endtask

  task automatic test_abort();
    start = 1'b1; op = OP_MULTU; rs = 32'hFFFF_FFFF; rt = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || alu_carry !== 1'b1 || alu_operation !== ALU_ADD) begin
      miscompares++;
      $display("FAIL abort_pre: busy=%b carry=%b op=%b, required 1/1/10", busy, alu_carry, alu_operation);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      miscompares++;
      $display("FAIL abort: busy=%b done=%b hi=%h lo=%h, required 0/0/0/0", busy, done, hi, lo);
    end
    check_alu_idle("abort_alu");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 1'b0);
    check_alu_idle("idle_alu");
    test_op("mult_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 36, 1'b0);
    test_op("mult_neg4xneg5", OP_MULT, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 32'd0, 32'd20, 35, 1'b0);
    test_op("mult_0xneg5", OP_MULT, 32'd0, 32'hFFFF_FFFB, 32'd0, 32'd0, 36, 1'b0);
    test_op("div_neg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 36, 1'b0);
    test_op("div_7byneg2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 35, 1'b0);
    test_op("divu_100by7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b0);
    test_op("div_intmin", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 36, 1'b0);
    test_op("back_to_back_hold", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1'b1);
    test_div0();
    test_abort();
    test_op("after_abort", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 33, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
